// File: rtl/video_sync_receiver.sv
// rtl/video_sync_receiver.sv - 3-bit RGB video link receiver with sync timing lock and pixel recovery
//
// Samples hsync/vsync/rgb once per pixel clock and measures the line length
// and lines per frame. After LOCK_FRAMES consecutive identical frames it
// locks, then emits one strobe per active pixel with its coordinates.
// Optional macro VIDEO_RX_CRC_EN adds a per-frame CRC-16-CCITT of the
// active pixels.
//
// Ports:
//   clk, reset        pixel clock; asynchronous active-high reset
//   hsync_in/vsync_in sync inputs, polarity set by SYNC_ACTIVE_LOW
//   rgb_in            pixel colour {b,g,r}
//   pix_valid/x/y/rgb active pixel strobe, column, row, colour
//   frame_start       pulse on each vsync leading edge while locked
//   locked            timing lock status
//   line_len          stored line length in clocks
//   frame_lines       stored lines per frame
//   sync_err          pulse when lock is lost
//   frame_crc         CRC of the previous fully locked frame (0 without VIDEO_RX_CRC_EN)

module video_sync_receiver #(
    parameter int H_ACTIVE        = 256,
    parameter int V_ACTIVE        = 240,
    parameter int H_START         = 46,
    parameter int V_START         = 8,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  rgb_in,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        sync_err,
    output logic [15:0] frame_crc
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic        SYNC_POL = (SYNC_ACTIVE_LOW != 0);
    localparam logic [10:0] H_BEG    = 11'(H_START);
    localparam logic [10:0] H_END    = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_BEG    = 10'(V_START);
    localparam logic [9:0]  V_END    = 10'(V_START + V_ACTIVE);
    localparam logic [2:0]  LOCK_N   = 3'(LOCK_FRAMES);
    localparam logic [10:0] H_MAX    = 11'h7FF;
    localparam logic [9:0]  V_MAX    = 10'h3FF;

    // input stage, syncs normalised to 1 = asserted
    logic       hs1, vs1, hs1_d, vs1_d;
    logic [2:0] rgb1;
    logic       h_edge, v_edge;

    logic [10:0] hcnt_q, hcnt_next, meas_len, cur_len;
    logic [9:0]  vline_q, vline_next;
    logic        seen_h, frame_has_line, line_bad;

    state_t      state, state_next;
    logic [2:0]  match_cnt, match_next;
    logic        store, err, act;

    assign h_edge = hs1 & ~hs1_d;
    assign v_edge = vs1 & ~vs1_d;

    // hcnt_next / vline_next are the counts that belong to the current s1 sample
    assign hcnt_next  = h_edge ? 11'd0 : ((hcnt_q == H_MAX) ? H_MAX : hcnt_q + 11'd1);
    assign meas_len   = (hcnt_q == H_MAX) ? H_MAX : hcnt_q + 11'd1;
    assign vline_next = v_edge ? 10'd0 :
                        ((h_edge && vline_q != V_MAX) ? vline_q + 10'd1 : vline_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs1            <= 1'b0;
            vs1            <= 1'b0;
            hs1_d          <= 1'b0;
            vs1_d          <= 1'b0;
            rgb1           <= 3'd0;
            hcnt_q         <= 11'd0;
            vline_q        <= 10'd0;
            cur_len        <= 11'd0;
            seen_h         <= 1'b0;
            frame_has_line <= 1'b0;
            line_bad       <= 1'b0;
        end else begin
            hs1     <= hsync_in ^ SYNC_POL;
            vs1     <= vsync_in ^ SYNC_POL;
            hs1_d   <= hs1;
            vs1_d   <= vs1;
            rgb1    <= rgb_in;
            hcnt_q  <= hcnt_next;
            vline_q <= vline_next;
            if (h_edge) begin
                cur_len <= meas_len;
                seen_h  <= 1'b1;
            end
            // a line only counts once a previous hsync edge gave it a start point
            if (v_edge) begin
                frame_has_line <= 1'b0;
                line_bad       <= 1'b0;
            end else if (h_edge && seen_h) begin
                frame_has_line <= 1'b1;
                if (frame_has_line && meas_len != cur_len)
                    line_bad <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        match_next = match_cnt;
        store      = 1'b0;
        err        = 1'b0;
        unique case (state)
            SEARCH: begin
                if (v_edge) begin
                    state_next = MEASURE;
                    match_next = 3'd0;
                end
            end
            MEASURE: begin
                if (v_edge) begin
                    if (line_bad || !frame_has_line) begin
                        match_next = 3'd0;
                    end else if (cur_len == line_len && vline_q == frame_lines) begin
                        match_next = match_cnt + 3'd1;
                    end else begin
                        store      = 1'b1;
                        match_next = 3'd1;
                    end
                    if (match_next == LOCK_N)
                        state_next = LOCKED;
                end
            end
            LOCKED: begin
                if ((h_edge && meas_len != line_len) ||
                    (v_edge && vline_q != frame_lines) ||
                    hcnt_next == H_MAX || vline_next == V_MAX) begin
                    err        = 1'b1;
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // judged on state_next so pixels stop in the same cycle lock is lost
    assign act = (state_next == LOCKED) &&
                 (hcnt_next >= H_BEG) && (hcnt_next < H_END) &&
                 (vline_next >= V_BEG) && (vline_next < V_END);

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            match_cnt   <= 3'd0;
            line_len    <= 11'd0;
            frame_lines <= 10'd0;
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= 9'd0;
            pix_y       <= 9'd0;
            pix_rgb     <= 3'd0;
        end else begin
            state       <= state_next;
            match_cnt   <= match_next;
            sync_err    <= err;
            frame_start <= v_edge && (state_next == LOCKED);
            if (store) begin
                line_len    <= cur_len;
                frame_lines <= vline_q;
            end
            pix_valid <= act;
            pix_x     <= 9'(hcnt_next - H_BEG);
            pix_y     <= 9'(vline_next - V_BEG);
            pix_rgb   <= rgb1;
        end
    end

`ifdef VIDEO_RX_CRC_EN
    logic [15:0] crc_q, frame_crc_q;
    logic        frame_ok;

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // frame_ok: lock held since this frame's opening vsync edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= 16'h0000;
            frame_ok    <= 1'b0;
        end else if (v_edge) begin
            if (frame_ok && !err)
                frame_crc_q <= crc_q;
            crc_q    <= 16'hFFFF;
            frame_ok <= (state_next == LOCKED);
        end else begin
            if (err)
                frame_ok <= 1'b0;
            if (act)
                crc_q <= crc_byte(crc_q, {5'b0, rgb1});
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_video_sync_receiver.sv
// tb/tb_video_sync_receiver.sv - directed self-checking bench for video_sync_receiver

`define CHK(tag, obs, exp) \
    begin \
        tests++; \
        assert (64'(obs) === 64'(exp)) else begin \
            fails++; \
            $error("FAIL %s: observed %0d expected %0d", tag, 64'(obs), 64'(exp)); \
        end \
    end

module tb_video_sync_receiver;

    localparam int HA   = 8;
    localparam int VA   = 4;
    localparam int HST  = 3;
    localparam int VST  = 2;
    localparam int LINE = 16;
    localparam int NL   = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync_in, vsync_in;
    logic [2:0]  rgb_in;
    logic        pix_valid, frame_start, locked, sync_err;
    logic [8:0]  pix_x, pix_y;
    logic [2:0]  pix_rgb;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [15:0] frame_crc;

    always #5 clk = ~clk;

    video_sync_receiver #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HST), .V_START(VST),
        .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
        .line_len(line_len), .frame_lines(frame_lines), .sync_err(sync_err),
        .frame_crc(frame_crc)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic       exp_lk = 1'b0;
    logic       d1_v = 1'b0, d2_v = 1'b0;
    logic [8:0] d1_x = '0, d2_x = '0, d1_y = '0, d2_y = '0;
    logic [2:0] d1_r = '0, d2_r = '0;

    int pv_cnt, pix_bad, err_cnt, fs_cnt;
    int err_cyc, fs_cyc, lk_rise, lk_fall;
    int first_x, first_y, last_x, last_y;
    int v_pin, h_pin;
    logic prev_lk = 1'b0;

    logic [15:0] acc = 16'hFFFF;
    logic [15:0] last_crc = 16'hFFFF;
    logic [15:0] crc_zero;

    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    task automatic clr();
        pv_cnt = 0; pix_bad = 0; err_cnt = 0; fs_cnt = 0;
        err_cyc = -1; fs_cyc = -1; lk_rise = -1; lk_fall = -1;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    endtask

    // sample outputs of this cycle, then drive the pins for this cycle
    task automatic step(input logic h, input logic v, input logic [2:0] r,
                        input logic act, input int x, input int y);
        @(posedge clk);
        #1;
        cyc++;
        if (pix_valid !== d2_v ||
            (d2_v && (pix_x !== d2_x || pix_y !== d2_y || pix_rgb !== d2_r)))
            pix_bad++;
        if (pix_valid === 1'b1) begin
            if (pv_cnt == 0) begin first_x = int'(pix_x); first_y = int'(pix_y); end
            last_x = int'(pix_x); last_y = int'(pix_y);
            pv_cnt++;
        end
        if (sync_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if (frame_start === 1'b1) begin fs_cnt++; fs_cyc = cyc; end
        if (locked === 1'b1 && !prev_lk) lk_rise = cyc;
        if (locked === 1'b0 && prev_lk)  lk_fall = cyc;
        prev_lk = (locked === 1'b1);
        d2_v = d1_v; d2_x = d1_x; d2_y = d1_y; d2_r = d1_r;
        d1_v = act & exp_lk; d1_x = 9'(x); d1_y = 9'(y); d1_r = r;
        if (act && exp_lk) acc = crc_model(acc, {5'b0, r});
        hsync_in = ~h;
        vsync_in = ~v;
        rgb_in   = r;
    endtask

    // one frame: vsync leading edge at line 0 clock 5, lasting two lines
    task automatic frame(input int nl, input int gl, input int glen, input logic lk_v,
                         input logic zero, input int flip_line, input int rst_line);
        for (int k = 0; k < nl; k++) begin
            int len;
            len = (k == gl) ? glen : LINE;
            for (int c = 0; c < len; c++) begin
                logic h, v, act;
                logic [2:0] r;
                int x, y;
                if (k == rst_line && c == 7) begin
                    reset = 1'b1;
                    #1;
                    `CHK("rst_outputs", {pix_valid, locked, frame_start, sync_err, line_len,
                                          frame_lines, pix_x, pix_y, pix_rgb, frame_crc}, 0)
                    d1_v = 1'b0; d2_v = 1'b0; exp_lk = 1'b0;
                    return;
                end
                h   = (c < 2);
                v   = (k == 0 && c >= 5) || k == 1 || (k == 2 && c < 5);
                act = (c >= HST) && (c < HST + HA) && (k >= VST) && (k < VST + VA);
                x   = c - HST;
                y   = k - VST;
                r   = act ? (zero ? 3'd0 : 3'((x + y) % 8)) : 3'd7;
                if (k == flip_line && c == HST) r = 3'd5;
                if (k == 0 && c == 5) begin
                    exp_lk   = lk_v;
                    last_crc = acc;
                    acc      = 16'hFFFF;
                end
                if (gl >= 0 && k == gl + 1 && c == 0) exp_lk = 1'b0;
                step(h, v, r, act, x, y);
                if (k == 0 && c == 5) v_pin = cyc;
                if (gl >= 0 && k == gl + 1 && c == 0) h_pin = cyc;
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        rgb_in   = 3'd0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        `CHK("reset_state", {pix_valid, locked, frame_start, sync_err, line_len,
                             frame_lines, pix_x, pix_y, pix_rgb, frame_crc}, 0)
        reset = 1'b0;

        // acquisition
        frame(NL, -1, 0, 1'b0, 1'b0, -1, -1);
        frame(NL, -1, 0, 1'b0, 1'b0, -1, -1);
        `CHK("line_len_stored", line_len, 16)
        `CHK("frame_lines_stored", frame_lines, 10)
        `CHK("not_locked_yet", locked, 0)

        clr();
        frame(NL, -1, 0, 1'b1, 1'b0, -1, -1);
        `CHK("lock_rise_cycle", lk_rise, v_pin + 2)
        `CHK("frame_start_cycle", fs_cyc, v_pin + 2)
        `CHK("strobes_per_frame", pv_cnt, HA * VA)
        `CHK("pixel_map", pix_bad, 0)
        `CHK("first_x", first_x, 0)
        `CHK("first_y", first_y, 0)
        `CHK("last_x", last_x, HA - 1)
        `CHK("last_y", last_y, VA - 1)
        `CHK("no_err_lock", err_cnt, 0)

        clr();
        frame(NL, -1, 0, 1'b1, 1'b1, -1, -1);
        `CHK("zero_frame_strobes", pv_cnt, HA * VA)
        `CHK("zero_frame_fs", fs_cnt, 1)
        `CHK("zero_frame_map", pix_bad, 0)

        // line glitch: line 4 shortened to 12 clocks
        clr();
        frame(NL, 4, 12, 1'b1, 1'b0, -1, -1);
        `CHK("line_glitch_err_cnt", err_cnt, 1)
        `CHK("line_glitch_err_cycle", err_cyc, h_pin + 2)
        `CHK("line_glitch_lock_fall", lk_fall, err_cyc)
        `CHK("line_glitch_strobes", pv_cnt, 3 * HA)
        `CHK("line_glitch_map", pix_bad, 0)
        `CHK("line_glitch_unlocked", locked, 0)
        crc_zero = last_crc;
`ifdef VIDEO_RX_CRC_EN
        `CHK("crc_zero_frame", frame_crc, crc_zero)
`else
        `CHK("crc_off_a", frame_crc, 0)
`endif

        clr();
        frame(NL, -1, 0, 1'b0, 1'b0, -1, -1);
`ifdef VIDEO_RX_CRC_EN
        `CHK("crc_hold", frame_crc, crc_zero)
`endif
        frame(NL, -1, 0, 1'b0, 1'b0, -1, -1);
        `CHK("relock_wait_unlocked", locked, 0)
        `CHK("relock_wait_no_pix", pv_cnt, 0)

        clr();
        frame(NL, -1, 0, 1'b1, 1'b1, 3, -1);
        `CHK("relock", locked, 1)
        `CHK("relock_strobes", pv_cnt, HA * VA)
        `CHK("relock_map", pix_bad, 0)

        // frame glitch: 9-line frame, caught at its closing vsync
        clr();
        frame(NL - 1, -1, 0, 1'b1, 1'b0, -1, -1);
        `CHK("short_frame_strobes", pv_cnt, HA * VA)
`ifdef VIDEO_RX_CRC_EN
        `CHK("crc_flip_model", frame_crc, last_crc)
        `CHK("crc_flip_differs", (frame_crc != crc_zero), 1)
`else
        `CHK("crc_off_b", frame_crc, 0)
`endif
        clr();
        frame(NL, -1, 0, 1'b0, 1'b0, -1, -1);
        `CHK("frame_glitch_err_cnt", err_cnt, 1)
        `CHK("frame_glitch_err_cycle", err_cyc, v_pin + 2)
        `CHK("frame_glitch_no_fs", fs_cnt, 0)
        `CHK("frame_glitch_no_pix", pv_cnt, 0)
        `CHK("frame_lines_held", frame_lines, 10)
        frame(NL, -1, 0, 1'b0, 1'b0, -1, -1);
        frame(NL, -1, 0, 1'b0, 1'b0, -1, -1);
        clr();
        frame(NL, -1, 0, 1'b1, 1'b0, -1, -1);
        `CHK("frame_glitch_relock", locked, 1)
        `CHK("frame_glitch_relock_map", pix_bad, 0)

        // reset mid-line while locked
        clr();
        frame(NL, -1, 0, 1'b1, 1'b0, -1, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 0, 0);
        reset = 1'b0;
        frame(NL, -1, 0, 1'b0, 1'b0, -1, -1);
        frame(NL, -1, 0, 1'b0, 1'b0, -1, -1);
        frame(NL, -1, 0, 1'b1, 1'b0, -1, -1);
        `CHK("reset_no_err", err_cnt, 0)
        `CHK("reset_relock", locked, 1)
        `CHK("reset_relock_map", pix_bad, 0)
        `CHK("reset_relock_len", line_len, 16)

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
